// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the write-back port arbiter.
// Optional feature macro: WB_RR_EN (round-robin contention resolution).
package wb_port_arbiter_pkg;

  localparam int REG_ID_W      = 4;
  localparam int DATA_W        = 16;
  localparam int WB_FIFO_DEPTH = 2;
  localparam int CNT_W         = 2;

  // One buffered register-file write
  typedef struct packed {
    logic [REG_ID_W-1:0] id;
    logic [DATA_W-1:0]   data;
  } wr_req_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_t;

  // Register id to pending-mask bit
  function automatic logic [(1<<REG_ID_W)-1:0] reg_onehot(input logic [REG_ID_W-1:0] r);
    return {{((1<<REG_ID_W)-1){1'b0}}, 1'b1} << r;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle for the write-back arbiter: two producer request ports,
// the registered register-file write port and the pending-write mask.
// Handshake: a request transfers on a rising edge where x_valid && x_ready;
// x_ready depends only on registered state, never on x_valid.
interface wb_port_arbiter_if;
  import wb_port_arbiter_pkg::*;

  logic                      a_valid;
  logic                      a_ready;
  logic [REG_ID_W-1:0]       a_reg;
  logic [DATA_W-1:0]         a_data;
  logic                      b_valid;
  logic                      b_ready;
  logic [REG_ID_W-1:0]       b_reg;
  logic [DATA_W-1:0]         b_data;
  logic                      WriteReg;
  logic [REG_ID_W-1:0]       DstReg;
  logic [DATA_W-1:0]         DstData;
  logic [(1<<REG_ID_W)-1:0]  pend_mask;

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output a_ready, b_ready, WriteReg, DstReg, DstData, pend_mask
  );

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  a_ready, b_ready, WriteReg, DstReg, DstData, pend_mask
  );

endinterface

// File: rtl/wb_fifo.sv
// Two-entry strict FIFO of write requests. Exposes count, head and the
// per-slot valid/reg view that the pending-write mask is built from.
module wb_fifo
  import wb_port_arbiter_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push,
  input  wr_req_t                            push_req,
  input  logic                               pop,
  output logic [CNT_W-1:0]                   count,
  output wr_req_t                            head,
  output logic [WB_FIFO_DEPTH-1:0]           slot_valid,
  output logic [WB_FIFO_DEPTH-1:0][REG_ID_W-1:0] slot_reg
);

  wr_req_t          mem [WB_FIFO_DEPTH];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push_ok;
  logic             pop_ok;

  // A full FIFO refuses pushes even when it pops in the same cycle
  assign push_ok = push && (cnt != CNT_W'(WB_FIFO_DEPTH));
  assign pop_ok  = pop && (cnt != '0);

  // Pointer and occupancy update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; contents are meaningless until marked valid
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_req;
  end

  // Per-slot occupancy view for the pending mask
  always_comb begin
    for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
      slot_valid[i] = (cnt == CNT_W'(2)) || ((cnt == CNT_W'(1)) && (rd_ptr == 1'(i)));
      slot_reg[i]   = mem[i].id;
    end
  end

  assign count = cnt;
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back arbiter: two buffered producer ports share one registered
// register-file write port. Writes to r0 are accepted and dropped.
// Optional feature macro: WB_RR_EN selects round-robin on contention;
// without it port A always wins contention.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  wb_port_arbiter_if.slave     bus
);

  logic [CNT_W-1:0]                      a_cnt, b_cnt;
  wr_req_t                               a_head, b_head;
  logic [WB_FIFO_DEPTH-1:0]              a_slot_valid, b_slot_valid;
  logic [WB_FIFO_DEPTH-1:0][REG_ID_W-1:0] a_slot_reg, b_slot_reg;
  logic                                  a_ready, b_ready;
  logic                                  a_push, b_push;
  logic                                  a_pop, b_pop;
  logic                                  a_ne, b_ne;
  logic                                  grant_any;
  port_sel_t                             grant_sel;
  wr_req_t                               grant_req;
  logic                                  write_reg_q;
  logic [REG_ID_W-1:0]                   dst_reg_q;
  logic [DATA_W-1:0]                     dst_data_q;
  logic [(1<<REG_ID_W)-1:0]              pend;

  assign a_ready = (a_cnt < CNT_W'(WB_FIFO_DEPTH));
  assign b_ready = (b_cnt < CNT_W'(WB_FIFO_DEPTH));

  // r0 writes complete the handshake but never enter a FIFO
  assign a_push = bus.a_valid && a_ready && (bus.a_reg != '0);
  assign b_push = bus.b_valid && b_ready && (bus.b_reg != '0);

  assign a_ne = (a_cnt != '0);
  assign b_ne = (b_cnt != '0);

  wb_fifo u_fifo_a (
    .clk        (clk),
    .rst        (rst),
    .push       (a_push),
    .push_req   ('{id: bus.a_reg, data: bus.a_data}),
    .pop        (a_pop),
    .count      (a_cnt),
    .head       (a_head),
    .slot_valid (a_slot_valid),
    .slot_reg   (a_slot_reg)
  );

  wb_fifo u_fifo_b (
    .clk        (clk),
    .rst        (rst),
    .push       (b_push),
    .push_req   ('{id: bus.b_reg, data: bus.b_data}),
    .pop        (b_pop),
    .count      (b_cnt),
    .head       (b_head),
    .slot_valid (b_slot_valid),
    .slot_reg   (b_slot_reg)
  );

`ifdef WB_RR_EN
  port_sel_t rr_ptr;

  // Flip the preferred port after every contended grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= PORT_A;
    end else if (a_ne && b_ne) begin
      rr_ptr <= (rr_ptr == PORT_A) ? PORT_B : PORT_A;
    end
  end
`endif

  // Pick which FIFO head goes to the write port this cycle
  always_comb begin
    grant_any = a_ne || b_ne;
    grant_sel = PORT_A;
    if (a_ne && b_ne) begin
`ifdef WB_RR_EN
      grant_sel = rr_ptr;
`else
      grant_sel = PORT_A;
`endif
    end else if (b_ne) begin
      grant_sel = PORT_B;
    end
    grant_req = (grant_sel == PORT_B) ? b_head : a_head;
    a_pop     = grant_any && (grant_sel == PORT_A);
    b_pop     = grant_any && (grant_sel == PORT_B);
  end

  // Registered write port; id/data hold while no write is issued
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_reg_q <= 1'b0;
      dst_reg_q   <= '0;
      dst_data_q  <= '0;
    end else begin
      write_reg_q <= grant_any;
      if (grant_any) begin
        dst_reg_q  <= grant_req.id;
        dst_data_q <= grant_req.data;
      end
    end
  end

  // Pending mask: every queued entry plus the write on the output port
  always_comb begin
    pend = '0;
    for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
      if (a_slot_valid[i]) pend = pend | reg_onehot(a_slot_reg[i]);
      if (b_slot_valid[i]) pend = pend | reg_onehot(b_slot_reg[i]);
    end
    if (write_reg_q) pend = pend | reg_onehot(dst_reg_q);
  end

  assign bus.a_ready   = a_ready;
  assign bus.b_ready   = b_ready;
  assign bus.WriteReg  = write_reg_q;
  assign bus.DstReg    = dst_reg_q;
  assign bus.DstData   = dst_data_q;
  assign bus.pend_mask = pend;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus ();

  wb_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;
  bit log_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [19:0] qa[$];
  logic [19:0] qb[$];
  logic        m_wr = 1'b0;
  logic [3:0]  m_dst = '0;
  logic [15:0] m_data = '0;
  bit          m_ptr_b = 1'b0;
  logic [15:0] m_rf [16];
  logic [15:0] dut_rf [16];
  int          sa, sb;
  bit          take_b, grant;
  logic [19:0] ent;

  initial for (int i = 0; i < 16; i++) begin
    m_rf[i] = '0;
    dut_rf[i] = '0;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      qa.delete();
      qb.delete();
      m_wr = 1'b0; m_dst = '0; m_data = '0; m_ptr_b = 1'b0;
    end else begin
      sa = qa.size();
      sb = qb.size();
      if (m_wr) m_rf[m_dst] = m_data;
      grant = (sa > 0) || (sb > 0);
      take_b = (sa == 0);
      if (sa > 0 && sb > 0) begin
`ifdef WB_RR_EN
        take_b = m_ptr_b;
        m_ptr_b = !m_ptr_b;
`else
        take_b = 1'b0;
`endif
      end
      if (grant) begin
        ent = take_b ? qb.pop_front() : qa.pop_front();
        m_wr = 1'b1; m_dst = ent[19:16]; m_data = ent[15:0];
      end else begin
        m_wr = 1'b0;
      end
      if (bus.a_valid && sa < 2 && bus.a_reg != 4'd0) qa.push_back({bus.a_reg, bus.a_data});
      if (bus.b_valid && sb < 2 && bus.b_reg != 4'd0) qb.push_back({bus.b_reg, bus.b_data});
    end
  end

  function automatic logic [15:0] model_mask();
    logic [15:0] m = '0;
    foreach (qa[i]) m |= 16'(1) << qa[i][19:16];
    foreach (qb[i]) m |= 16'(1) << qb[i][19:16];
    if (m_wr) m |= 16'(1) << m_dst;
    return m;
  endfunction

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("a_ready",   32'(bus.a_ready),   32'(qa.size() < 2));
      check("b_ready",   32'(bus.b_ready),   32'(qb.size() < 2));
      check("WriteReg",  32'(bus.WriteReg),  32'(m_wr));
      check("DstReg",    32'(bus.DstReg),    32'(m_dst));
      check("DstData",   32'(bus.DstData),   32'(m_data));
      check("pend_mask", 32'(bus.pend_mask), 32'(model_mask()));
    end
  end

  // Bench-side register file fed by the DUT port; a write lands at the edge
  logic        cap_wr = 1'b0;
  logic [3:0]  cap_reg;
  logic [15:0] cap_data;
  logic [3:0]  glog[$];

  always @(negedge clk) begin
    cap_wr   = (bus.WriteReg === 1'b1);
    cap_reg  = bus.DstReg;
    cap_data = bus.DstData;
    if (log_en && bus.WriteReg === 1'b1) glog.push_back(bus.DstReg);
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) cap_wr = 1'b0;
    else if (cap_wr) dut_rf[cap_reg] = cap_data;
  end

  // ---------------- driver tasks ----------------
  task automatic send_a(input logic [3:0] r, input logic [15:0] d);
    bit got;
    int t = 0;
    bus.a_valid = 1'b1; bus.a_reg = r; bus.a_data = d;
    do begin
      got = bus.a_ready;
      @(posedge clk); #1;
      t++;
    end while (!got && t < 50);
    bus.a_valid = 1'b0;
    check("a_accept", 32'(got), 32'd1);
  endtask

  task automatic send_b(input logic [3:0] r, input logic [15:0] d);
    bit got;
    int t = 0;
    bus.b_valid = 1'b1; bus.b_reg = r; bus.b_data = d;
    do begin
      got = bus.b_ready;
      @(posedge clk); #1;
      t++;
    end while (!got && t < 50);
    bus.b_valid = 1'b0;
    check("b_accept", 32'(got), 32'd1);
  endtask

  task automatic stream_a(input int n, input logic [3:0] base, input logic [15:0] dbase);
    for (int i = 0; i < n; i++) send_a(base + 4'(i), dbase + 16'(i));
  endtask

  task automatic stream_b(input int n, input logic [3:0] base, input logic [15:0] dbase);
    for (int i = 0; i < n; i++) send_b(base + 4'(i), dbase + 16'(i));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  logic [3:0] exp_order [8];

  initial begin
    bus.a_valid = 1'b0; bus.a_reg = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_reg = '0; bus.b_data = '0;
`ifdef WB_RR_EN
    exp_order = '{4'd1, 4'd5, 4'd2, 4'd6, 4'd3, 4'd7, 4'd4, 4'd8};
`else
    exp_order = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
`endif
    #1 rst = 1'b0;
    cmp_en = 1'b1;
    idle(3);
    rst = 1'b1;

    // Reset values
    @(negedge clk);
    check("rst_WriteReg",  32'(bus.WriteReg),  32'd0);
    check("rst_DstReg",    32'(bus.DstReg),    32'd0);
    check("rst_DstData",   32'(bus.DstData),   32'd0);
    check("rst_a_ready",   32'(bus.a_ready),   32'd1);
    check("rst_b_ready",   32'(bus.b_ready),   32'd1);
    check("rst_pend_mask", 32'(bus.pend_mask), 32'd0);

    // First write: accepted at edge k, on the port after edge k+1
    @(posedge clk); #1;
    send_a(4'd3, 16'h1234);
    @(negedge clk);
    check("first_pend_queued", 32'(bus.pend_mask), 32'h0008);
    check("first_no_bypass",   32'(bus.WriteReg),  32'd0);
    @(negedge clk);
    check("first_WriteReg", 32'(bus.WriteReg), 32'd1);
    check("first_DstReg",   32'(bus.DstReg),   32'd3);
    check("first_DstData",  32'(bus.DstData),  32'h1234);
    @(negedge clk);
    check("first_pend_clear", 32'(bus.pend_mask), 32'd0);
    #1;

    // r0 write is accepted and dropped
    send_a(4'd0, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("r0_WriteReg",  32'(bus.WriteReg),  32'd0);
      check("r0_pend_mask", 32'(bus.pend_mask), 32'd0);
    end
    idle(1);

    // Contention / backpressure: both ports stream four writes
    glog.delete();
    log_en = 1'b1;
    fork
      stream_a(4, 4'd1, 16'hA000);
      stream_b(4, 4'd5, 16'hB000);
    join
    idle(6);
    log_en = 1'b0;
    check("grant_count", 32'(glog.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < glog.size()) check("grant_order", 32'(glog[i]), 32'(exp_order[i]));
    end

    // Reset in the middle of a burst
    bus.a_valid = 1'b1; bus.a_reg = 4'd9;  bus.a_data = 16'h9999;
    bus.b_valid = 1'b1; bus.b_reg = 4'd10; bus.b_data = 16'hAAAA;
    idle(3);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_WriteReg",  32'(bus.WriteReg),  32'd0);
    check("mid_rst_DstReg",    32'(bus.DstReg),    32'd0);
    check("mid_rst_DstData",   32'(bus.DstData),   32'd0);
    check("mid_rst_a_ready",   32'(bus.a_ready),   32'd1);
    check("mid_rst_b_ready",   32'(bus.b_ready),   32'd1);
    check("mid_rst_pend_mask", 32'(bus.pend_mask), 32'd0);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    idle(1);
    rst = 1'b1;
    idle(1);

    // Same register from both ports in one cycle
    fork
      send_a(4'd5, 16'h5555);
      send_b(4'd5, 16'hBBBB);
    join
    @(negedge clk);
    check("same_pend_q",    32'(bus.pend_mask[5]), 32'd1);
    @(negedge clk);
    check("same_pend_out1", 32'(bus.pend_mask[5]), 32'd1);
    check("same_first",     32'(bus.DstData),      32'h5555);
    @(negedge clk);
    check("same_pend_out2", 32'(bus.pend_mask[5]), 32'd1);
    check("same_second",    32'(bus.DstData),      32'hBBBB);
    @(negedge clk);
    check("same_pend_done", 32'(bus.pend_mask[5]), 32'd0);
    idle(2);
    check("same_rf5", 32'(dut_rf[5]), 32'hBBBB);

    // One port alone sustains a request per cycle
    stream_b(6, 4'd9, 16'hC000);
    idle(6);

    // Register-file contents against the model
    for (int r = 1; r < 16; r++) check("rf_final", 32'(dut_rf[r]), 32'(m_rf[r]));

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Write-back arbiter for the 16×16 register file's single write port. Two producers (ALU and memory load) present `(register, data)` write requests through a valid/ready handshake. Each request is buffered in a 2-entry per-port FIFO and granted one per cycle onto a registered write port (`WriteReg`/`DstReg`/`DstData`). A pending-write mask tells decode which registers still have a write in flight.

## Interface
- Parameters: none. Widths fixed: 16-bit data, 4-bit register id, FIFO depth 2.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `a_valid` input 1: ALU write request valid.
- `a_ready` output 1: ALU FIFO can accept.
- `a_reg` input 4: ALU destination register.
- `a_data` input 16: ALU write data.
- `b_valid` input 1: memory-load write request valid.
- `b_ready` output 1: memory-load FIFO can accept.
- `b_reg` input 4: memory-load destination register.
- `b_data` input 16: memory-load write data.
- `WriteReg` output 1: register-file write enable (registered).
- `DstReg` output 4: register-file write id (registered).
- `DstData` output 16: register-file write data (registered).
- `pend_mask` output 16: bit r set while a write to r is queued or sitting on the output port.

## Operation
- Accept on port X when `x_valid && x_ready` at a rising edge.
- `x_ready` = (FIFO X count < 2), from registered count only.
  - No push when full, even if a pop occurs in the same cycle.
- Writes to register 0 are accepted (handshake completes) and discarded.
  - Never enqueued; never appear on `WriteReg`; never set `pend_mask`.
- Each FIFO is strict FIFO; same-port order is always preserved.
- Arbitration each cycle over the FIFO heads:
  - One head non-empty: grant it.
  - Both non-empty: resolved per Configuration.
  - Neither non-empty: no grant.
- Grant pops the head at the edge. The same edge loads `WriteReg`=1, `DstReg`, `DstData` from that head.
- With no grant, the edge loads `WriteReg`=0. `DstReg`/`DstData` hold their previous values.
- Cross-port order to the same register is grant order; the later grant's data wins in the register file.
- `pend_mask` is combinational: OR of one-hot(reg) over valid entries of both FIFOs plus the output stage when `WriteReg`=1.
- Reset values: `WriteReg`=0, `DstReg`=0, `DstData`=0, both FIFOs empty, `a_ready`=`b_ready`=1, `pend_mask`=0, round-robin pointer = "A next".
- Reset mid-operation discards all queued and in-flight writes immediately (asynchronous). No partial write is issued.

## Timing
- Request accepted at edge k → earliest `WriteReg`=1 after edge k+1 → register file writes at edge k+2.
- No same-cycle bypass from input to output.
- Sustained throughput: one write per cycle in total across both ports.
- Each port sustains one request per cycle while the other port is idle. Depth 2 covers the ready-to-pop turnaround.
- `pend_mask` bit for r rises after the accept edge. It falls after the edge where the output stage stops holding r (edge k+2 for an uncontended request).

## Configuration
- `WB_RR_EN` defined: round-robin.
  - On contention, grant the port indicated by the pointer.
  - After every contended grant, the pointer flips to the other port. Uncontended grants leave the pointer unchanged.
- `WB_RR_EN` undefined: fixed priority, port A (ALU) always wins contention. The pointer flop is not built.

## Structure
- Shared package holds:
  - `REG_ID_W`=4, `DATA_W`=16, `WB_FIFO_DEPTH`=2.
  - Write-request struct {reg id, data}.
  - Port-select enum {PORT_A, PORT_B}.
- One sub-module, `wb_fifo`: 2-entry FIFO with push/pop, count, head, and per-entry valid/reg outputs for the pending mask. Instantiated twice.
- Arbiter, output register and mask logic live in the top module.

## Test plan
- Reset: assert `rst`=0 mid-burst → all outputs at reset values immediately. After release, the first accepted A write (r3, 0x1234) gives `WriteReg`=1, `DstReg`=3, `DstData`=0x1234 two edges later.
- R0 drop: A sends r0, 0xFFFF → `a_ready` handshake completes. `WriteReg` stays 0 and `pend_mask` stays 0.
- Backpressure: hold `a_valid` with 4 writes (r1..r4) while B is kept contending with 4 writes (r5..r8) → `a_ready` drops at count 2. Issue order is exact per port; no loss or duplication.
- Contention, `WB_RR_EN` defined: both ports stream continuously → grants alternate A,B,A,B starting with A after reset.
- Contention, `WB_RR_EN` undefined: both ports stream → all A grants first; B granted only when A is empty.
- Pending mask: A writes r5, B writes r5 in the same cycle → `pend_mask`[5] stays 1 until the second write leaves the output stage. The register file ends with the second-granted data.
